// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl
//   Instruction fetch controller. It holds the program counter, drives the
//   instruction ROM and registers the returned word into the IF/ID stage.
//   It supports stalls, taken-branch redirects (including branches that
//   arrive while stalled), flush redirects, and a sticky fault for
//   misaligned or out-of-range fetch addresses.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   ROM_WORDS   instruction ROM depth in 32-bit words
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   stall        hold pc and the IF/ID register
//   branch_flag  taken-branch request from ID
//   branch_addr  target of that branch
//   flush        exception/flush redirect request
//   new_pc       target of that flush
//   rom_ce       ROM chip enable
//   rom_addr     ROM byte address (the current pc)
//   rom_inst     combinational ROM read data for rom_addr
//   if_pc        IF/ID: pc of the delivered instruction
//   if_inst      IF/ID: delivered instruction word
//   if_valid     IF/ID: instruction is valid
//   fault        sticky fetch-address fault
//   fetch_cnt    number of valid instructions delivered (wraps)

module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        fault,
  output logic [31:0] fetch_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [31:0] ROM_WORDS_U = ROM_WORDS;

  logic [1:0]  state;
  logic [31:0] pc;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic        pc_bad;

  // The pc is unusable if it is not word aligned or points past the ROM.
  assign pc_bad = (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= ROM_WORDS_U);

  // The ROM is only enabled while actively fetching; the address is the pc.
  assign rom_ce   = (state == S_RUN);
  assign rom_addr = pc;

  // Per-edge priority: rst, flush, then state-specific behaviour. Within
  // S_RUN a bad pc takes precedence over stall/branch because the word at
  // that address can never be delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      if_pc      <= 32'h0;
      if_inst    <= 32'h0;
      if_valid   <= 1'b0;
      fault      <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= 32'h0;
      fetch_cnt  <= 32'h0;
    end else if (flush) begin
      state      <= S_RUN;
      pc         <= new_pc;
      if_valid   <= 1'b0;
      if_inst    <= 32'h0;
      pend_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_RUN;
          pc    <= RESET_PC;
        end
        S_RUN: begin
          if (pc_bad) begin
            state      <= S_FAULT;
            fault      <= 1'b1;
            if_valid   <= 1'b0;
            pend_valid <= 1'b0;
          end else if (stall) begin
            // Remember the branch so it is not lost; the latest one wins.
            if (branch_flag) begin
              pend_valid <= 1'b1;
              pend_addr  <= branch_addr;
            end
          end else if (branch_flag) begin
            // A fresh branch supersedes any branch remembered from a stall.
            pc         <= branch_addr;
            if_valid   <= 1'b0;
            if_inst    <= 32'h0;
            pend_valid <= 1'b0;
          end else if (pend_valid) begin
            pc         <= pend_addr;
            if_valid   <= 1'b0;
            if_inst    <= 32'h0;
            pend_valid <= 1'b0;
          end else begin
            if_inst   <= rom_inst;
            if_pc     <= pc;
            if_valid  <= 1'b1;
            pc        <= pc + 32'd4;
            fetch_cnt <= fetch_cnt + 32'd1;
          end
        end
        S_FAULT: begin
          if_valid <= 1'b0;
          fault    <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          pc    <= RESET_PC;
        end
      endcase
    end
  end

endmodule
